// File: rtl/hack_pkg.sv
// Shared definitions for the Hack boot loader: default widths and the loader state type.
package hack_pkg;

  localparam int HACK_WORD_W = 16;
  localparam int HACK_ADDR_W = 15;

  typedef enum logic [2:0] {
    S_LEN  = 3'd0,
    S_DATA = 3'd1,
    S_CSUM = 3'd2,
    S_HOLD = 3'd3,
    S_RUN  = 3'd4,
    S_ERR  = 3'd5
  } state_e;

endpackage

// File: rtl/hack_boot_loader.sv
// Streams a length/data/checksum frame into the instruction ROM and holds the CPU in reset
// until a frame with a matching checksum has been written.
module hack_boot_loader
  import hack_pkg::*;
#(
  parameter int WORD_W      = HACK_WORD_W,
  parameter int ADDR_W      = HACK_ADDR_W,
  parameter int HOLD_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [WORD_W-1:0] in_data,
  output logic              in_ready,
  input  logic              boot_req,
  output logic              rom_we,
  output logic [ADDR_W-1:0] rom_addr,
  output logic [WORD_W-1:0] rom_wdata,
  output logic              cpu_reset,
  output logic              done,
  output logic              error,
  output logic [2:0]        state_dbg
);

  // Handshake: a stream word is consumed on a rising edge where in_valid && in_ready;
  // in_ready depends only on the state and reset, never on in_valid.

  // Remaining-count width must hold N == 2^ADDR_W; the compare width holds both N and that cap.
  localparam int CNT_W = ADDR_W + 1;
  localparam int CMP_W = (WORD_W > CNT_W) ? WORD_W + 1 : CNT_W + 1;
  localparam int HLD_W = (HOLD_CYCLES > 0) ? $clog2(HOLD_CYCLES + 1) : 1;

  state_e            state;
  logic [CNT_W-1:0]  remain;
  logic [ADDR_W-1:0] addr_cnt;
  logic [WORD_W-1:0] sum;
  logic [HLD_W-1:0]  hold_cnt;

  logic [CMP_W-1:0]  len_ext;
  logic [CMP_W-1:0]  capacity;
  logic              accept;

  assign len_ext  = CMP_W'(in_data);
  assign capacity = CMP_W'(1) << ADDR_W;

  assign in_ready  = !reset && (state == S_LEN || state == S_DATA || state == S_CSUM);
  assign accept    = in_valid && in_ready;
  assign cpu_reset = (state != S_RUN);
  assign done      = (state == S_RUN);
  assign error     = (state == S_ERR);
  assign state_dbg = state;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_LEN;
      remain    <= '0;
      addr_cnt  <= '0;
      sum       <= '0;
      hold_cnt  <= '0;
      rom_we    <= 1'b0;
      rom_addr  <= '0;
      rom_wdata <= '0;
    end else begin
      rom_we <= 1'b0;
      case (state)
        S_LEN: begin
          if (accept) begin
            if (len_ext > capacity) begin
              state <= S_ERR;
            end else if (len_ext == '0) begin
              state <= S_CSUM;
            end else begin
              state  <= S_DATA;
              remain <= CNT_W'(in_data);
            end
          end
        end
        S_DATA: begin
          if (accept) begin
            rom_we    <= 1'b1;
            rom_addr  <= addr_cnt;
            rom_wdata <= in_data;
            addr_cnt  <= addr_cnt + ADDR_W'(1);
            sum       <= sum + in_data;
            remain    <= remain - CNT_W'(1);
            if (remain == CNT_W'(1)) state <= S_CSUM;
          end
        end
        S_CSUM: begin
          if (accept) begin
            if (in_data != sum) begin
              state <= S_ERR;
            end else if (HOLD_CYCLES > 0) begin
              state    <= S_HOLD;
              hold_cnt <= HLD_W'(HOLD_CYCLES);
            end else begin
              state <= S_RUN;
            end
          end
        end
        S_HOLD: begin
          // Leaves on the edge that ends the HOLD_CYCLES-th cycle spent here.
          if (hold_cnt <= HLD_W'(1)) state <= S_RUN;
          else hold_cnt <= hold_cnt - HLD_W'(1);
        end
        S_RUN, S_ERR: begin
          if (boot_req) begin
            state    <= S_LEN;
            remain   <= '0;
            addr_cnt <= '0;
            sum      <= '0;
          end
        end
        default: state <= S_LEN;
      endcase
    end
  end

endmodule

// File: tb/tb_hack_boot_loader.sv
// Directed and randomized frames against two loader instances (default hold and zero hold).
module tb_hack_boot_loader;
  import hack_pkg::*;

  localparam int WW = 16;
  localparam int AW = 15;
  localparam int W  = AW + WW;

  // clock / reset
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic          v = 1'b0;
  logic          b = 1'b0;
  logic          sel = 1'b0;
  logic [WW-1:0] d = '0;

  logic          rdy_a, we_a, cr_a, done_a, err_a;
  logic [AW-1:0] addr_a;
  logic [WW-1:0] wd_a;
  logic [2:0]    st_a;
  logic          rdy_b, we_b, cr_b, done_b, err_b;
  logic [AW-1:0] addr_b;
  logic [WW-1:0] wd_b;
  logic [2:0]    st_b;

  hack_boot_loader #(.WORD_W(WW), .ADDR_W(AW), .HOLD_CYCLES(2)) dut (
    .clk(clk), .reset(reset), .in_valid(v & ~sel), .in_data(d), .in_ready(rdy_a),
    .boot_req(b & ~sel), .rom_we(we_a), .rom_addr(addr_a), .rom_wdata(wd_a),
    .cpu_reset(cr_a), .done(done_a), .error(err_a), .state_dbg(st_a)
  );

  hack_boot_loader #(.WORD_W(WW), .ADDR_W(AW), .HOLD_CYCLES(0)) dut0 (
    .clk(clk), .reset(reset), .in_valid(v & sel), .in_data(d), .in_ready(rdy_b),
    .boot_req(b & sel), .rom_we(we_b), .rom_addr(addr_b), .rom_wdata(wd_b),
    .cpu_reset(cr_b), .done(done_b), .error(err_b), .state_dbg(st_b)
  );

  logic          rdy, we, cr, dn, er;
  logic [AW-1:0] addr;
  logic [WW-1:0] wd;
  logic [2:0]    st;
  assign rdy  = sel ? rdy_b  : rdy_a;
  assign we   = sel ? we_b   : we_a;
  assign cr   = sel ? cr_b   : cr_a;
  assign dn   = sel ? done_b : done_a;
  assign er   = sel ? err_b  : err_a;
  assign addr = sel ? addr_b : addr_a;
  assign wd   = sel ? wd_b   : wd_a;
  assign st   = sel ? st_b   : st_a;

  // scoreboard
  int checks = 0;
  int failures = 0;
  logic [W-1:0]  exp_q[$];
  logic [W-1:0]  obs_q[$];
  logic [WW-1:0] data_q[$];

  always @(negedge clk) if (we === 1'b1) obs_q.push_back({addr, wd});

  initial begin
    #3000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // driver tasks
  task automatic push(input logic [WW-1:0] w, input bit gap, input bit noise);
    int n;
    if (gap) begin
      v = 1'b0;
      b = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      tick();
    end
    v = 1'b1;
    d = w;
    b = noise ? 1'($urandom_range(0, 1)) : 1'b0;
    n = 0;
    while (rdy !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    chk("accept_wait", 32'(rdy), 32'd1);
    tick();
  endtask

  task automatic boot();
    b = 1'b1;
    tick();
    b = 1'b0;
    chk("boot_cpu_reset", 32'(cr), 32'd1);
    chk("boot_done", 32'(dn), 32'd0);
    chk("boot_error", 32'(er), 32'd0);
    chk("boot_ready", 32'(rdy), 32'd1);
    chk("boot_state", 32'(st), 32'(S_LEN));
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_cpu_reset"}, 32'(cr), 32'd1);
    chk({tag, "_done"}, 32'(dn), 32'd0);
    chk({tag, "_error"}, 32'(er), 32'd0);
    chk({tag, "_rom_we"}, 32'(we), 32'd0);
    chk({tag, "_rom_addr"}, 32'(addr), 32'd0);
    chk({tag, "_rom_wdata"}, 32'(wd), 32'd0);
    chk({tag, "_ready_low"}, 32'(rdy), 32'd0);
    chk({tag, "_state"}, 32'(st), 32'(S_LEN));
  endtask

  // Reference model: a frame is good iff its length fits the ROM and its checksum equals
  // the 16-bit wrapped sum of the data; data word k lands at address k.
  task automatic run_frame(input logic [WW-1:0] len, input bit gaps,
                           input logic [WW-1:0] delta, input bit noise);
    int unsigned total;
    logic [WW-1:0] cs;
    logic [WW-1:0] model_sum;
    int hold;
    int n;
    hold  = sel ? 0 : 2;
    total = 0;
    obs_q.delete();
    exp_q.delete();
    push(len, gaps, noise);
    if (int'(len) > (1 << AW)) begin
      b = 1'b0;
      chk("ovf_error", 32'(er), 32'd1);
      chk("ovf_cpu_reset", 32'(cr), 32'd1);
      chk("ovf_ready", 32'(rdy), 32'd0);
      v = 1'b1;
      d = 16'($urandom);
      tick();
      tick();
      v = 1'b0;
      chk("ovf_no_write", 32'(obs_q.size()), 32'd0);
      chk("ovf_sticky", 32'(er), 32'd1);
      return;
    end
    for (int k = 0; k < int'(len); k++) begin
      push(data_q[k], gaps, noise);
      chk("we_pulse", 32'(we), 32'd1);
      chk("wr_addr", 32'(addr), 32'(k));
      chk("wr_data", 32'(wd), 32'(data_q[k]));
      exp_q.push_back({AW'(k), data_q[k]});
      total += int'(data_q[k]);
    end
    model_sum = 16'(total % 65536);
    cs = model_sum + delta;
    push(cs, gaps, noise);
    v = 1'b0;
    b = 1'b0;
    chk("csum_no_we", 32'(we), 32'd0);
    if (cs == model_sum) begin
      for (int i = 0; i < hold; i++) begin
        chk("hold_cpu_reset", 32'(cr), 32'd1);
        chk("hold_done", 32'(dn), 32'd0);
        tick();
      end
      chk("run_cpu_reset", 32'(cr), 32'd0);
      chk("run_done", 32'(dn), 32'd1);
      chk("run_error", 32'(er), 32'd0);
      chk("run_ready", 32'(rdy), 32'd0);
    end else begin
      chk("err_error", 32'(er), 32'd1);
      chk("err_cpu_reset", 32'(cr), 32'd1);
      chk("err_ready", 32'(rdy), 32'd0);
      chk("err_done", 32'(dn), 32'd0);
    end
    tick();
    chk("wr_count", 32'(obs_q.size()), 32'(exp_q.size()));
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) chk("wr_entry", 32'(obs_q[i]), 32'(exp_q[i]));
  endtask

  task automatic fill_random(input int n);
    data_q.delete();
    repeat (n) data_q.push_back(16'($urandom));
  endtask

  initial begin
    reset = 1'b1;
    repeat (2) tick();
    check_reset_outputs("reset");
    reset = 1'b0;
    #1;
    chk("reset_release_ready", 32'(rdy), 32'd1);

    data_q = '{16'h0001, 16'h0002, 16'h0003};
    run_frame(16'd3, 1'b0, 16'h0000, 1'b0);

    boot();
    data_q = '{16'hFFFF, 16'h0002};
    run_frame(16'd2, 1'b1, 16'h0000, 1'b0);

    boot();
    data_q = '{16'h0010, 16'h0020};
    run_frame(16'd2, 1'b0, 16'h0001, 1'b0);
    boot();
    fill_random(3);
    run_frame(16'd3, 1'b0, 16'h0000, 1'b0);

    boot();
    run_frame(16'h8001, 1'b0, 16'h0000, 1'b0);
    boot();
    data_q.delete();
    run_frame(16'd0, 1'b0, 16'h0000, 1'b0);

    // Reset lands on the edge that would have accepted the third data word.
    boot();
    obs_q.delete();
    fill_random(4);
    push(16'd4, 1'b0, 1'b0);
    push(data_q[0], 1'b0, 1'b0);
    push(data_q[1], 1'b0, 1'b0);
    reset = 1'b1;
    v = 1'b1;
    d = data_q[2];
    tick();
    check_reset_outputs("midreset");
    reset = 1'b0;
    v = 1'b0;
    tick();
    chk("midreset_no_we", 32'(we), 32'd0);
    chk("midreset_writes", 32'(obs_q.size()), 32'd2);
    fill_random(4);
    run_frame(16'd4, 1'b0, 16'h0000, 1'b0);

    for (int f = 0; f < 6; f++) begin
      int n;
      logic [WW-1:0] delta;
      boot();
      n = $urandom_range(1, 8);
      fill_random(n);
      delta = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(1, 65535)) : 16'h0000;
      run_frame(16'(n), 1'($urandom_range(0, 1)), delta, 1'b1);
    end

    sel = 1'b1;
    reset = 1'b1;
    repeat (2) tick();
    check_reset_outputs("hold0_reset");
    reset = 1'b0;
    #1;
    fill_random(3);
    run_frame(16'd3, 1'b0, 16'h0000, 1'b0);
    boot();
    fill_random(5);
    run_frame(16'd5, 1'b1, 16'h0000, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
